// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared types and constants for the decode stage: FSM state
//               encoding, MIPS instruction field positions, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Default widths
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_N  = 32;
    localparam int DEF_PC_W   = 32;

    // MIPS instruction field positions
    localparam int INSTR_W   = 32;
    localparam int OP_LSB    = 26;
    localparam int OP_W      = 6;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_LSB = 0;
    localparam int FUNCT_W   = 6;
    localparam int IMM_W     = 16;
    localparam int TGT_W     = 26;

    // Decode control FSM
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Fetch / hazard / writeback / ID-EX bundle of the decode stage.
//               master = surrounding pipeline, slave = decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int DATA_W = decode_pkg::DEF_DATA_W,
    parameter int ADDR_W = $clog2(decode_pkg::DEF_REG_N),
    parameter int PC_W   = decode_pkg::DEF_PC_W
);
    // fetch handshake
    logic              i_valid;
    logic              o_ready;
    logic [PC_W-1:0]   i_pc;
    logic [31:0]       i_instr;
    // decoded control
    logic              i_reg_dst;
    logic              i_reg_write;
    logic              i_mem_read;
    logic              i_jump;
    logic              i_beq;
    logic              i_bne;
    // downstream / in-flight state
    logic              i_ex_ready;
    logic [ADDR_W-1:0] i_ex_wr_addr;
    logic [ADDR_W-1:0] i_mem_wr_addr;
    logic              i_ex_reg_write;
    logic              i_ex_mem_read;
    logic              i_mem_reg_write;
    logic [DATA_W-1:0] i_ex_res;
    logic [DATA_W-1:0] i_mem_res;
    // writeback port
    logic              i_wb_we;
    logic [ADDR_W-1:0] i_wb_addr;
    logic [DATA_W-1:0] i_wb_data;
    // ID/EX register and redirect
    logic              o_valid;
    logic [DATA_W-1:0] o_op1;
    logic [DATA_W-1:0] o_op2;
    logic [DATA_W-1:0] o_imm;
    logic [ADDR_W-1:0] o_wr_addr;
    logic              o_reg_write;
    logic              o_mem_read;
    logic [PC_W-1:0]   o_next_pc;
    logic              o_pcsrc;
    logic              o_stall;

    modport master (
        output i_valid, i_pc, i_instr,
        output i_reg_dst, i_reg_write, i_mem_read, i_jump, i_beq, i_bne,
        output i_ex_ready, i_ex_wr_addr, i_mem_wr_addr,
        output i_ex_reg_write, i_ex_mem_read, i_mem_reg_write, i_ex_res, i_mem_res,
        output i_wb_we, i_wb_addr, i_wb_data,
        input  o_ready, o_valid, o_op1, o_op2, o_imm, o_wr_addr,
        input  o_reg_write, o_mem_read, o_next_pc, o_pcsrc, o_stall
    );

    modport slave (
        input  i_valid, i_pc, i_instr,
        input  i_reg_dst, i_reg_write, i_mem_read, i_jump, i_beq, i_bne,
        input  i_ex_ready, i_ex_wr_addr, i_mem_wr_addr,
        input  i_ex_reg_write, i_ex_mem_read, i_mem_reg_write, i_ex_res, i_mem_res,
        input  i_wb_we, i_wb_addr, i_wb_data,
        output o_ready, o_valid, o_op1, o_op2, o_imm, o_wr_addr,
        output o_reg_write, o_mem_read, o_next_pc, o_pcsrc, o_stall
    );

endinterface
`default_nettype wire

// File: rtl/decode_stage_regfile.sv
`default_nettype none
// ============================================================================
// Module      : decode_regfile
// Description : REG_N x DATA_W register file, two read ports, one write
//               port. Reads are write-first; register 0 is hard-wired zero.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32,
    parameter int ADDR_W = $clog2(REG_N)
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               we,
    input  wire  [ADDR_W-1:0] waddr,
    input  wire  [DATA_W-1:0] wdata,
    input  wire  [ADDR_W-1:0] raddr_a,
    input  wire  [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem [REG_N];

    // Storage: clear on reset, never write register 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: a same-cycle write to the read address is bypassed.
    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
        if (raddr_a == '0)                rdata_a = '0;
        else if (we && (waddr == raddr_a)) rdata_a = wdata;
        if (raddr_b == '0)                rdata_b = '0;
        else if (we && (waddr == raddr_b)) rdata_b = wdata;
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : MIPS decode stage: register read with hazard handling,
//               branch/jump resolution and ID/EX pipeline register.
//               Macro DECODE_STAGE_FWD_EN: defined -> EX/MEM operand
//               forwarding; undefined -> stall on any in-flight RAW.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_N  = DEF_REG_N,
    parameter int ADDR_W = $clog2(REG_N),
    parameter int PC_W   = DEF_PC_W
) (
    input  wire           i_clk,
    input  wire           i_rst,
    decode_stage_if.slave bus
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] rs, rt, rd;
    logic [IMM_W-1:0]  imm16;
    logic [DATA_W-1:0] rf_rd_a, rf_rd_b, op1, op2;
    logic              rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
    logic              load_use, hazard_src, hazard, taken;
    logic              ready, stall, pcsrc, load_idex, bubble;
    logic [PC_W-1:0]   pc_plus4, simm_pc, br_target, jmp_target, redirect_pc;
    logic              unused_fields;

    logic              idex_valid, idex_reg_write, idex_mem_read;
    logic [DATA_W-1:0] idex_op1, idex_op2, idex_imm;
    logic [ADDR_W-1:0] idex_wr_addr;

    assign rs    = bus.i_instr[RS_LSB +: ADDR_W];
    assign rt    = bus.i_instr[RT_LSB +: ADDR_W];
    assign rd    = bus.i_instr[RD_LSB +: ADDR_W];
    assign imm16 = bus.i_instr[IMM_W-1:0];
    // opcode/funct are decoded upstream into the control inputs
    assign unused_fields = ^{bus.i_instr[OP_LSB +: OP_W], bus.i_instr[FUNCT_LSB +: FUNCT_W]};

    decode_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (i_clk),
        .rst     (i_rst),
        .we      (bus.i_wb_we),
        .waddr   (bus.i_wb_addr),
        .wdata   (bus.i_wb_data),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rf_rd_a),
        .rdata_b (rf_rd_b)
    );

    assign rs_ex_hit  = (rs != '0) && (rs == bus.i_ex_wr_addr);
    assign rt_ex_hit  = (rt != '0) && (rt == bus.i_ex_wr_addr);
    assign rs_mem_hit = (rs != '0) && (rs == bus.i_mem_wr_addr);
    assign rt_mem_hit = (rt != '0) && (rt == bus.i_mem_wr_addr);

    // A load in EX cannot supply its data yet, so a consumer must wait.
    assign load_use = bus.i_ex_mem_read && (rs_ex_hit || rt_ex_hit);

`ifdef DECODE_STAGE_FWD_EN
    assign hazard_src = load_use;
`else
    logic unused_results;
    assign unused_results = ^{bus.i_ex_res, bus.i_mem_res};
    // Without forwarding every in-flight producer of a source blocks decode.
    assign hazard_src = load_use
                     || (bus.i_ex_reg_write  && (rs_ex_hit  || rt_ex_hit))
                     || (bus.i_mem_reg_write && (rs_mem_hit || rt_mem_hit));
`endif
    assign hazard = bus.i_valid && hazard_src;

    // Operand select: youngest in-flight producer beats the register file.
    always_comb begin
        op1 = rf_rd_a;
        op2 = rf_rd_b;
`ifdef DECODE_STAGE_FWD_EN
        if (rs_ex_hit && bus.i_ex_reg_write)        op1 = bus.i_ex_res;
        else if (rs_mem_hit && bus.i_mem_reg_write) op1 = bus.i_mem_res;
        if (rt_ex_hit && bus.i_ex_reg_write)        op2 = bus.i_ex_res;
        else if (rt_mem_hit && bus.i_mem_reg_write) op2 = bus.i_mem_res;
`endif
    end

    // Branch and jump resolution (all arithmetic wraps at PC_W bits).
    assign pc_plus4    = bus.i_pc + PC_W'(4);
    assign simm_pc     = {{(PC_W-IMM_W){imm16[IMM_W-1]}}, imm16};
    assign br_target   = pc_plus4 + (simm_pc << 2);
    assign jmp_target  = {pc_plus4[PC_W-1:TGT_W+2], bus.i_instr[TGT_W-1:0], 2'b00};
    assign taken       = bus.i_jump
                      || (bus.i_beq && (op1 == op2))
                      || (bus.i_bne && (op1 != op2));
    assign redirect_pc = bus.i_jump ? jmp_target : br_target;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_RUN;
        else       state <= state_nx;
    end

    // Next state and handshake. STALL marks the reissue cycle after a
    // bubble; the held instruction is decoded there exactly as in RUN.
    always_comb begin
        state_nx  = state;
        ready     = 1'b0;
        stall     = 1'b0;
        pcsrc     = 1'b0;
        load_idex = 1'b0;
        bubble    = 1'b0;
        if (!i_rst && bus.i_ex_ready) begin
            case (state)
                ST_FLUSH: begin
                    ready    = 1'b1;
                    bubble   = 1'b1;
                    state_nx = ST_RUN;
                end
                default: begin
                    if (hazard) begin
                        stall    = 1'b1;
                        bubble   = 1'b1;
                        state_nx = ST_STALL;
                    end else begin
                        ready    = 1'b1;
                        state_nx = ST_RUN;
                        if (bus.i_valid) begin
                            load_idex = 1'b1;
                            if (taken) begin
                                pcsrc    = 1'b1;
                                state_nx = ST_FLUSH;
                            end
                        end else begin
                            bubble = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // ID/EX register: load on accept, clear on bubble, hold otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst || bubble) begin
            idex_valid     <= 1'b0;
            idex_op1       <= '0;
            idex_op2       <= '0;
            idex_imm       <= '0;
            idex_wr_addr   <= '0;
            idex_reg_write <= 1'b0;
            idex_mem_read  <= 1'b0;
        end else if (load_idex) begin
            idex_valid     <= 1'b1;
            idex_op1       <= op1;
            idex_op2       <= op2;
            idex_imm       <= {{(DATA_W-IMM_W){imm16[IMM_W-1]}}, imm16};
            idex_wr_addr   <= bus.i_reg_dst ? rd : rt;
            idex_reg_write <= bus.i_reg_write;
            idex_mem_read  <= bus.i_mem_read;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_stall     = stall;
    assign bus.o_pcsrc     = pcsrc;
    assign bus.o_next_pc   = pcsrc ? redirect_pc : pc_plus4;
    assign bus.o_valid     = idex_valid;
    assign bus.o_op1       = idex_op1;
    assign bus.o_op2       = idex_op2;
    assign bus.o_imm       = idex_imm;
    assign bus.o_wr_addr   = idex_wr_addr;
    assign bus.o_reg_write = idex_reg_write;
    assign bus.o_mem_read  = idex_mem_read;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage: directed scenarios
//               followed by random traffic against a cycle reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.DATA_W(32), .ADDR_W(5), .PC_W(32)) bus ();

    decode_stage #(.DATA_W(32), .REG_N(32), .ADDR_W(5), .PC_W(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    localparam logic [31:0] ADD_3_1_2 = 32'h0022_1820;  // add $3,$1,$2
    localparam logic [31:0] BEQ_1_1_3 = 32'h1021_0003;  // beq $1,$1,+3
    localparam logic [31:0] J_40      = 32'h0800_0040;  // j 0x40

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_regs [32];
    logic        m_flush;
    logic        e_valid, e_rw, e_mr;
    logic [31:0] e_op1, e_op2, e_imm;
    logic [4:0]  e_wr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.i_valid = 0; bus.i_pc = 0; bus.i_instr = 0;
        bus.i_reg_dst = 0; bus.i_reg_write = 0; bus.i_mem_read = 0;
        bus.i_jump = 0; bus.i_beq = 0; bus.i_bne = 0;
        bus.i_ex_ready = 1; bus.i_ex_wr_addr = 0; bus.i_mem_wr_addr = 0;
        bus.i_ex_reg_write = 0; bus.i_ex_mem_read = 0; bus.i_mem_reg_write = 0;
        bus.i_ex_res = 0; bus.i_mem_res = 0;
        bus.i_wb_we = 0; bus.i_wb_addr = 0; bus.i_wb_data = 0;
    endtask

    // Value a source register should deliver this cycle.
    function automatic logic [31:0] operand(input logic [4:0] a);
        if (a == 0) return 32'd0;
`ifdef DECODE_STAGE_FWD_EN
        if (bus.i_ex_reg_write && bus.i_ex_wr_addr == a)   return bus.i_ex_res;
        if (bus.i_mem_reg_write && bus.i_mem_wr_addr == a) return bus.i_mem_res;
`endif
        if (bus.i_wb_we && bus.i_wb_addr == a) return bus.i_wb_data;
        return m_regs[a];
    endfunction

    // One clock: check combinational outputs, advance model, check ID/EX.
    task automatic step();
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, pc4, tgt, x_npc, n_op1, n_op2, n_imm;
        logic        x_ready, x_stall, x_pcsrc, taken, hz, in_ex, in_mem;
        logic        n_v, n_rw, n_mr, n_flush;
        logic [4:0]  n_wr;
        int          si;
        #1;
        rs = bus.i_instr[25:21];
        rt = bus.i_instr[20:16];
        rd = bus.i_instr[15:11];
        a  = operand(rs);
        b  = operand(rt);
        si = $signed(bus.i_instr[15:0]);
        pc4 = bus.i_pc + 32'd4;
        taken = bus.i_jump || (bus.i_beq && a == b) || (bus.i_bne && a != b);
        if (bus.i_jump) tgt = (pc4 & 32'hF000_0000) | {4'd0, bus.i_instr[25:0], 2'b00};
        else            tgt = pc4 + si * 4;
        in_ex  = bus.i_ex_wr_addr != 0 && (rs == bus.i_ex_wr_addr || rt == bus.i_ex_wr_addr);
        in_mem = bus.i_mem_wr_addr != 0 && (rs == bus.i_mem_wr_addr || rt == bus.i_mem_wr_addr);
`ifdef DECODE_STAGE_FWD_EN
        hz = bus.i_ex_mem_read && in_ex;
`else
        hz = ((bus.i_ex_mem_read || bus.i_ex_reg_write) && in_ex) || (bus.i_mem_reg_write && in_mem);
`endif
        hz = hz && bus.i_valid;

        x_ready = 0; x_stall = 0; x_pcsrc = 0;
        n_v = e_valid; n_op1 = e_op1; n_op2 = e_op2; n_imm = e_imm;
        n_wr = e_wr; n_rw = e_rw; n_mr = e_mr; n_flush = m_flush;
        if (rst) begin
            {n_v, n_rw, n_mr} = 3'b000; n_op1 = 0; n_op2 = 0; n_imm = 0; n_wr = 0; n_flush = 0;
        end else if (bus.i_ex_ready) begin
            if (m_flush || hz || !bus.i_valid) begin
                {n_v, n_rw, n_mr} = 3'b000; n_op1 = 0; n_op2 = 0; n_imm = 0; n_wr = 0;
                x_ready = !hz || m_flush;
                x_stall = hz && !m_flush;
                n_flush = 0;
            end else begin
                x_ready = 1;
                n_v = 1; n_op1 = a; n_op2 = b; n_imm = si;
                n_wr = bus.i_reg_dst ? rd : rt;
                n_rw = bus.i_reg_write; n_mr = bus.i_mem_read;
                x_pcsrc = taken;
                n_flush = taken;
            end
        end
        x_npc = x_pcsrc ? tgt : pc4;
        check("ready", bus.o_ready, x_ready);
        check("stall", bus.o_stall, x_stall);
        check("pcsrc", bus.o_pcsrc, x_pcsrc);
        check("next_pc", bus.o_next_pc, x_npc);

        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
        end else if (bus.i_wb_we && bus.i_wb_addr != 0) begin
            m_regs[bus.i_wb_addr] = bus.i_wb_data;
        end
        e_valid = n_v; e_op1 = n_op1; e_op2 = n_op2; e_imm = n_imm;
        e_wr = n_wr; e_rw = n_rw; e_mr = n_mr; m_flush = n_flush;
        #1;
        check("o_valid", bus.o_valid, e_valid);
        check("o_op1", bus.o_op1, e_op1);
        check("o_op2", bus.o_op2, e_op2);
        check("o_imm", bus.o_imm, e_imm);
        check("o_wr_addr", bus.o_wr_addr, e_wr);
        check("o_reg_write", bus.o_reg_write, e_rw);
        check("o_mem_read", bus.o_mem_read, e_mr);
    endtask

    initial begin
        logic [31:0] w;
        m_flush = 0;
        clear_inputs();

        // reset
        rst = 1;
        #1; check("rst_ready", bus.o_ready, 0);
        step();
        check("rst_valid", bus.o_valid, 0);
        check("rst_op1", bus.o_op1, 0);
        rst = 0;

        // preload $1=5, $2=7 through writeback
        bus.i_wb_we = 1; bus.i_wb_addr = 1; bus.i_wb_data = 5; step();
        bus.i_wb_addr = 2; bus.i_wb_data = 7; step();
        bus.i_wb_we = 0;

        // add $3,$1,$2 from register file
        bus.i_valid = 1; bus.i_pc = 32'h40; bus.i_instr = ADD_3_1_2;
        bus.i_reg_dst = 1; bus.i_reg_write = 1;
        step();
        check("add_op1", bus.o_op1, 5);
        check("add_op2", bus.o_op2, 7);
        check("add_wr", bus.o_wr_addr, 3);
        check("add_valid", bus.o_valid, 1);

        // EX and MEM both writing $1
        bus.i_pc = 32'h44;
        bus.i_ex_reg_write = 1; bus.i_ex_wr_addr = 1; bus.i_ex_res = 9;
        bus.i_mem_reg_write = 1; bus.i_mem_wr_addr = 1; bus.i_mem_res = 4;
`ifdef DECODE_STAGE_FWD_EN
        step();
        check("fwd_ex_op1", bus.o_op1, 9);
`else
        step();
        check("raw_stall", bus.o_stall, 1);
        check("raw_bubble", bus.o_valid, 0);
        bus.i_ex_reg_write = 0;
        step();
        check("raw_mem_bubble", bus.o_valid, 0);
        bus.i_mem_reg_write = 0;
        step();
        check("raw_clear_op1", bus.o_op1, 5);
`endif
        bus.i_ex_reg_write = 0; bus.i_mem_reg_write = 0;

        // lw $2 in EX, consumer reads $2
        bus.i_pc = 32'h48;
        bus.i_ex_mem_read = 1; bus.i_ex_reg_write = 1; bus.i_ex_wr_addr = 2;
        #1;
        check("lu_stall", bus.o_stall, 1);
        check("lu_ready", bus.o_ready, 0);
        step();
        check("lu_bubble", bus.o_valid, 0);
        bus.i_ex_mem_read = 0; bus.i_ex_reg_write = 0; bus.i_ex_wr_addr = 0;
        bus.i_mem_reg_write = 1; bus.i_mem_wr_addr = 2; bus.i_mem_res = 32'h55;
`ifdef DECODE_STAGE_FWD_EN
        #1; check("lu_one_cycle", bus.o_stall, 0);
        step();
        check("lu_reissue_op2", bus.o_op2, 32'h55);
`else
        step();
        bus.i_mem_reg_write = 0;
        step();
        check("lu_reissue_op2", bus.o_op2, 7);
`endif
        check("lu_reissue_valid", bus.o_valid, 1);
        bus.i_mem_reg_write = 0;

        // taken beq at 0x100, then a wrong-path instruction
        bus.i_pc = 32'h100; bus.i_instr = BEQ_1_1_3; bus.i_beq = 1;
        bus.i_reg_dst = 0; bus.i_reg_write = 0;
        #1;
        check("beq_pcsrc", bus.o_pcsrc, 1);
        check("beq_target", bus.o_next_pc, 32'h110);
        step();
        bus.i_pc = 32'h104; bus.i_instr = BEQ_1_1_3;
        #1;
        check("flush_ready", bus.o_ready, 1);
        check("flush_no_redirect", bus.o_pcsrc, 0);
        step();
        check("flush_discard", bus.o_valid, 0);

        // jump, followed by an idle flush cycle
        bus.i_beq = 0; bus.i_jump = 1;
        bus.i_pc = 32'h2000_0010; bus.i_instr = J_40;
        #1; check("j_target", bus.o_next_pc, 32'h2000_0100);
        step();
        bus.i_valid = 0; bus.i_jump = 0;
        step();

        // downstream stall holds ID/EX for three cycles
        bus.i_valid = 1; bus.i_pc = 32'h200; bus.i_instr = ADD_3_1_2;
        bus.i_reg_dst = 1; bus.i_reg_write = 1;
        step();
        bus.i_ex_ready = 0; bus.i_pc = 32'h204; bus.i_instr = BEQ_1_1_3; bus.i_beq = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_ready", bus.o_ready, 0);
            check("hold_op1", bus.o_op1, 5);
            check("hold_wr", bus.o_wr_addr, 3);
        end
        bus.i_ex_ready = 1; bus.i_beq = 0; bus.i_instr = ADD_3_1_2;

        // reset while in STALL
        bus.i_ex_mem_read = 1; bus.i_ex_wr_addr = 2;
        step();
        rst = 1;
        step();
        check("rst_stall_valid", bus.o_valid, 0);
        rst = 0; bus.i_ex_mem_read = 0; bus.i_ex_wr_addr = 0;
        #1; check("rst_stall_run", bus.o_ready, 1);
        step();
        check("post_rst_op1", bus.o_op1, 0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            w = $urandom;
            w[25:21] = 5'($urandom_range(0, 7));
            w[20:16] = 5'($urandom_range(0, 7));
            bus.i_instr         = w;
            bus.i_valid         = $urandom_range(0, 3) != 0;
            bus.i_pc            = $urandom & 32'hFFFF_FFFC;
            bus.i_reg_dst       = 1'($urandom);
            bus.i_reg_write     = 1'($urandom);
            bus.i_mem_read      = 1'($urandom);
            bus.i_jump          = $urandom_range(0, 9) == 0;
            bus.i_beq           = $urandom_range(0, 5) == 0;
            bus.i_bne           = $urandom_range(0, 5) == 0;
            bus.i_ex_ready      = $urandom_range(0, 7) != 0;
            bus.i_ex_wr_addr    = 5'($urandom_range(0, 7));
            bus.i_mem_wr_addr   = 5'($urandom_range(0, 7));
            bus.i_ex_reg_write  = $urandom_range(0, 2) == 0;
            bus.i_ex_mem_read   = $urandom_range(0, 4) == 0;
            bus.i_mem_reg_write = $urandom_range(0, 2) == 0;
            bus.i_ex_res        = $urandom;
            bus.i_mem_res       = $urandom;
            bus.i_wb_we         = 1'($urandom);
            bus.i_wb_addr       = 5'($urandom_range(0, 7));
            bus.i_wb_data       = $urandom;
            rst                 = $urandom_range(0, 99) == 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, operand/register width
- REG_N, 32, register count (power of 2)
- ADDR_W, $clog2(REG_N), register address width
- PC_W, 32, program counter width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  fetch presents instruction
- o_ready  out  1  decode accepts instruction this cycle
- i_pc  in  PC_W  PC of presented instruction
- i_instr  in  32  MIPS instruction word
- i_reg_dst, i_reg_write, i_mem_read, i_jump, i_beq, i_bne  in  1 each  decoded control
- i_ex_ready  in  1  execute stage can accept
- i_ex_wr_addr, i_mem_wr_addr  in  ADDR_W  destinations in EX, MEM
- i_ex_reg_write, i_ex_mem_read, i_mem_reg_write  in  1 each  in-flight write/load flags
- i_ex_res, i_mem_res  in  DATA_W  EX result, MEM result
- i_wb_we  in  1; i_wb_addr  in  ADDR_W; i_wb_data  in  DATA_W  writeback port
- o_valid  out  1  ID/EX register holds valid instruction
- o_op1, o_op2, o_imm  out  DATA_W  registered operands, sign-extended imm16
- o_wr_addr  out  ADDR_W; o_reg_write, o_mem_read  out  1  registered
- o_next_pc  out  PC_W; o_pcsrc  out  1  combinational redirect
- o_stall  out  1  hazard stall asserted

Function
REQ-003 Register file SHALL hold REG_N x DATA_W; register 0 SHALL read 0 and ignore writes.
REQ-004 Reads SHALL be write-first: read of i_wb_addr while i_wb_we returns i_wb_data.
REQ-005 Operand priority SHALL be EX (i_ex_res) > MEM (i_mem_res) > WB > regfile, matched on rs/rt, reg-write set, address nonzero.
REQ-006 Load-use: rs or rt equals i_ex_wr_addr with i_ex_mem_read=1 (nonzero) SHALL assert o_stall, deassert o_ready, insert bubble (o_valid=0) for exactly one cycle.
REQ-007 FSM states: RUN, STALL, FLUSH. RUN->STALL on load-use; STALL->RUN next cycle; RUN->FLUSH on accepted redirect; FLUSH->RUN next cycle.
REQ-008 In FLUSH, the presented instruction (wrong path) SHALL be consumed (o_ready=1) and discarded (o_valid=0 next cycle).
REQ-009 Branch/jump SHALL resolve in decode: beq taken if op1==op2, bne if op1!=op2; target pc+4+(simm16<<2); jump target {pc+4[PC_W-1:28], instr[25:0], 2'b00}.
REQ-010 o_pcsrc SHALL assert only when i_valid, o_ready, state RUN, branch taken or jump; o_next_pc=pc+4 otherwise.
REQ-011 o_wr_addr SHALL be rd if i_reg_dst else rt.
REQ-012 Downstream stall (i_ex_ready=0) SHALL hold ID/EX register, o_ready=0, o_pcsrc=0, FSM unchanged; has priority over load-use bubble.
REQ-013 Latency: accepted instruction SHALL appear on ID/EX outputs one cycle after acceptance.
REQ-014 Arithmetic SHALL wrap modulo 2^PC_W.

Reset
REQ-015 On i_rst: state RUN, o_valid=0, all ID/EX outputs 0, all registers 0; reset mid-stall/flush SHALL abandon it.
REQ-016 o_ready SHALL be 0 during reset cycle.

Configuration
REQ-017 Macro DECODE_STAGE_FWD_EN: defined -> REQ-005 forwarding; undefined -> operands from regfile/WB bypass only, and any RAW on an in-flight EX or MEM writer SHALL stall (REQ-006 mechanism) until it clears.

Structure
REQ-018 Package decode_pkg SHALL hold state enum, opcode/funct field positions, default widths.
REQ-019 Sub-module decode_regfile (2R1W, write-first) SHALL be instantiated once.

Verification
REQ-020 add $3,$1,$2 with $1=5,$2=7 in regfile -> next cycle o_op1=5, o_op2=7, o_wr_addr=3.
REQ-021 EX writes $1 res=9, MEM writes $1 res=4, instr reads $1 -> o_op1=9 (FWD_EN) / stall until clear (undefined).
REQ-022 lw $2 in EX (i_ex_mem_read=1), instr reads $2 -> o_stall=1 one cycle, one o_valid=0 bubble, then reissue.
REQ-023 beq at pc=0x100, op1==op2, imm=0x0003 -> o_pcsrc=1, o_next_pc=0x110, next instruction discarded.
REQ-024 i_ex_ready=0 for 3 cycles during valid stream -> ID/EX outputs hold, no accept; i_rst during STALL -> RUN, o_valid=0.
